// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the sequential multiplier.
// Holds the MulCtl operation encodings, the controller state enum, the
// iteration count and small decode helpers used by mul_sequencer.
package mul_pkg;

  // MulCtl encodings; bit 0 is the set-flags (S) bit
  localparam logic [3:0] MULCTL_MUL    = 4'b0000;
  localparam logic [3:0] MULCTL_MULS   = 4'b0001;
  localparam logic [3:0] MULCTL_UMULL  = 4'b0100;
  localparam logic [3:0] MULCTL_UMULLS = 4'b0101;
  localparam logic [3:0] MULCTL_SMULL  = 4'b0110;
  localparam logic [3:0] MULCTL_SMULLS = 4'b0111;

  localparam int         MUL_ITERS = 32;
  localparam logic [4:0] LAST_ITER = 5'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic ctl_supported(input logic [3:0] ctl);
    case (ctl)
      MULCTL_MUL, MULCTL_MULS, MULCTL_UMULL,
      MULCTL_UMULLS, MULCTL_SMULL, MULCTL_SMULLS: ctl_supported = 1'b1;
      default:                                    ctl_supported = 1'b0;
    endcase
  endfunction

  function automatic logic ctl_signed(input logic [3:0] ctl);
    case (ctl)
      MULCTL_SMULL, MULCTL_SMULLS: ctl_signed = 1'b1;
      default:                     ctl_signed = 1'b0;
    endcase
  endfunction

  function automatic logic ctl_long(input logic [3:0] ctl);
    case (ctl)
      MULCTL_UMULL, MULCTL_UMULLS,
      MULCTL_SMULL, MULCTL_SMULLS: ctl_long = 1'b1;
      default:                     ctl_long = 1'b0;
    endcase
  endfunction

  // Unsigned magnitude of an operand. For 0x80000000 the negate wraps back
  // to 0x80000000, which read as unsigned is exactly 2^31, so 32 bits suffice.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      magnitude = ~v + 32'd1;
    end else begin
      magnitude = v;
    end
  endfunction

endpackage

// File: rtl/mul_shiftadd_core.sv
// mul_shiftadd_core: radix-2 shift-add datapath with iteration counter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture multiplicand/multiplier, clear counter
//   step            one shift-add iteration, counter increments
//   negate          two's-complement negate the 64-bit accumulator
//   mcand, mplier   unsigned operand magnitudes (used with load)
//   acc             64-bit accumulator (final product after 32 steps)
//   last_iter       counter holds the final iteration index
module mul_shiftadd_core
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        negate,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic [63:0] acc,
  output logic        last_iter
);

  logic [63:0] acc_r;
  logic [31:0] mcand_r;
  logic [4:0]  count_r;
  logic [32:0] sum_s;

  // Upper half plus multiplicand when the multiplier LSB (acc[0]) is set;
  // the 33rd bit is the carry that shifts back into acc[63].
  always_comb begin
    sum_s = {1'b0, acc_r[63:32]};
    if (acc_r[0]) begin
      sum_s = {1'b0, acc_r[63:32]} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r[63:32]};
    end
  end

  // Accumulator, multiplicand and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= 64'd0;
      mcand_r <= 32'd0;
      count_r <= 5'd0;
    end else if (load) begin
      acc_r   <= {32'd0, mplier};
      mcand_r <= mcand;
      count_r <= 5'd0;
    end else if (step) begin
      acc_r   <= {sum_s, acc_r[31:1]};
      count_r <= count_r + 5'd1;
    end else if (negate) begin
      acc_r   <= ~acc_r + 64'd1;
    end
  end

  assign acc       = acc_r;
  assign last_iter = (count_r == LAST_ITER);

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: 32-cycle sequential multiplier controller (MUL/UMULL/SMULL
// with optional N/Z flags).
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   Start, MulCtl        begin operation / operation select (sampled in IDLE)
//   SrcA, SrcB           32-bit operands, sampled with Start
//   Flush                synchronous abort, higher priority than Start
//   Busy                 controller is in ITER, SIGN or DONE
//   Done                 one-cycle pulse with the registered result
//   ResultLo, ResultHi   product words, held until the next completion
//   FlagsNZ, FlagsValid  {N,Z} flags and their qualifier (S bit of MulCtl)
// Results and flags are registered on the edge that leaves DONE, so Done is
// seen in the cycle after that edge: 34 clocks after acceptance.
module mul_sequencer
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MulCtl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ResultLo,
  output logic [31:0] ResultHi,
  output logic [1:0]  FlagsNZ,
  output logic        FlagsValid
);

  state_t      state_r;
  logic [3:0]  ctl_r;
  logic        neg_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic [1:0]  nz_r;
  logic        fv_r;

  logic        signed_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        load_s;
  logic        step_s;
  logic        negate_s;
  logic [63:0] acc_s;
  logic        last_iter_s;
  logic [31:0] prod_lo_s;
  logic [31:0] prod_hi_s;
  logic [1:0]  prod_nz_s;

  // Operand magnitudes and datapath controls; Flush suppresses all of them
  always_comb begin
    signed_s = ctl_signed(MulCtl);
    mag_a_s  = magnitude(SrcA, signed_s);
    mag_b_s  = magnitude(SrcB, signed_s);
    load_s   = (state_r == IDLE) && Start && ctl_supported(MulCtl) && !Flush;
    step_s   = (state_r == ITER) && !Flush;
    negate_s = (state_r == SIGN) && neg_r && !Flush;
  end

  mul_shiftadd_core u_core (
    .clk       (clk),
    .rst_n     (reset),
    .load      (load_s),
    .step      (step_s),
    .negate    (negate_s),
    .mcand     (mag_a_s),
    .mplier    (mag_b_s),
    .acc       (acc_s),
    .last_iter (last_iter_s)
  );

  // Result words and N/Z for the latched operation width
  always_comb begin
    prod_lo_s = acc_s[31:0];
    if (ctl_long(ctl_r)) begin
      prod_hi_s = acc_s[63:32];
      prod_nz_s = {acc_s[63], (acc_s == 64'd0)};
    end else begin
      prod_hi_s = 32'd0;
      prod_nz_s = {acc_s[31], (acc_s[31:0] == 32'd0)};
    end
  end

  // Controller FSM with registered status and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ctl_r   <= 4'd0;
      neg_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      lo_r    <= 32'd0;
      hi_r    <= 32'd0;
      nz_r    <= 2'd0;
      fv_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      nz_r   <= 2'd0;
      fv_r   <= 1'b0;
      if (Flush) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (load_s) begin
              ctl_r   <= MulCtl;
              neg_r   <= signed_s && (SrcA[31] ^ SrcB[31]);
              busy_r  <= 1'b1;
              state_r <= ITER;
            end
          end
          ITER: begin
            if (last_iter_s) begin
              state_r <= SIGN;
            end
          end
          SIGN: begin
            state_r <= DONE;
          end
          DONE: begin
            lo_r    <= prod_lo_s;
            hi_r    <= prod_hi_s;
            nz_r    <= prod_nz_s;
            fv_r    <= ctl_r[0];
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign Busy       = busy_r;
  assign Done       = done_r;
  assign ResultLo   = lo_r;
  assign ResultHi   = hi_r;
  assign FlagsNZ    = nz_r;
  assign FlagsValid = fv_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MulCtl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] ResultLo;
  logic [31:0] ResultHi;
  logic [1:0]  FlagsNZ;
  logic        FlagsValid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_sequencer u_dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .MulCtl     (MulCtl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .Flush      (Flush),
    .Busy       (Busy),
    .Done       (Done),
    .ResultLo   (ResultLo),
    .ResultHi   (ResultHi),
    .FlagsNZ    (FlagsNZ),
    .FlagsValid (FlagsValid)
  );

  // Present one Start for one edge, then wait (bounded) for Done.
  // Returns the number of clocks from acceptance to Done, or -1 on timeout.
  task automatic run_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    MulCtl = ctl; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (Done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; Start = 1'b0; Flush = 1'b0;
    MulCtl = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({Busy, Done, FlagsValid, FlagsNZ} !== 5'b0) begin errors++; $display("FAIL reset_status: got %b want 00000", {Busy, Done, FlagsValid, FlagsNZ}); end
    checks++; if (ResultLo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", ResultLo); end
    checks++; if (ResultHi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", ResultHi); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_umull_max();
    int lat;
    run_op(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL umull_latency: got %0d want 34", lat); end
    checks++; if (ResultHi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umull_hi: got %h want fffffffe", ResultHi); end
    checks++; if (ResultLo !== 32'h0000_0001) begin errors++; $display("FAIL umull_lo: got %h want 00000001", ResultLo); end
    checks++; if (FlagsValid !== 1'b0) begin errors++; $display("FAIL umull_fv: got %b want 0", FlagsValid); end
    @(posedge clk); #1;
    checks++; if ({Done, FlagsValid, FlagsNZ} !== 4'b0) begin errors++; $display("FAIL umull_after_done: got %b want 0000", {Done, FlagsValid, FlagsNZ}); end
    checks++; if (ResultLo !== 32'h0000_0001) begin errors++; $display("FAIL umull_held: got %h want 00000001", ResultLo); end
  endtask

  task automatic test_smulls();
    int lat;
    run_op(4'b0111, 32'hFFFF_FFFE, 32'h0000_0003, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL smulls_latency: got %0d want 34", lat); end
    checks++; if ({ResultHi, ResultLo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL smulls_result: got %h_%h want ffffffff_fffffffa", ResultHi, ResultLo); end
    checks++; if (FlagsNZ !== 2'b10) begin errors++; $display("FAIL smulls_nz: got %b want 10", FlagsNZ); end
    checks++; if (FlagsValid !== 1'b1) begin errors++; $display("FAIL smulls_fv: got %b want 1", FlagsValid); end
    // -2^31 * 1: negative result through the 2^31 magnitude path
    run_op(4'b0111, 32'h8000_0000, 32'h0000_0001, lat);
    checks++; if ({ResultHi, ResultLo} !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL smulls_min: got %h_%h want ffffffff_80000000", ResultHi, ResultLo); end
    checks++; if (FlagsNZ !== 2'b10) begin errors++; $display("FAIL smulls_min_nz: got %b want 10", FlagsNZ); end
  endtask

  task automatic test_short_and_min();
    int lat;
    run_op(4'b0001, 32'h0001_0000, 32'h0001_0000, lat);
    checks++; if ({ResultHi, ResultLo} !== 64'd0) begin errors++; $display("FAIL muls_result: got %h_%h want 0_0", ResultHi, ResultLo); end
    checks++; if (FlagsNZ !== 2'b01) begin errors++; $display("FAIL muls_nz: got %b want 01", FlagsNZ); end
    checks++; if (FlagsValid !== 1'b1) begin errors++; $display("FAIL muls_fv: got %b want 1", FlagsValid); end
    // product 0x1_0001_0000: high bits must be dropped for MUL
    run_op(4'b0000, 32'h0001_0000, 32'h0001_0001, lat);
    checks++; if ({ResultHi, ResultLo} !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL mul_trunc: got %h_%h want 00000000_00010000", ResultHi, ResultLo); end
    checks++; if (FlagsValid !== 1'b0) begin errors++; $display("FAIL mul_fv: got %b want 0", FlagsValid); end
    run_op(4'b0110, 32'h8000_0000, 32'h8000_0000, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL smull_min_latency: got %0d want 34", lat); end
    checks++; if ({ResultHi, ResultLo} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL smull_min: got %h_%h want 40000000_00000000", ResultHi, ResultLo); end
  endtask

  task automatic test_ignored_starts();
    int done_cnt = 0;
    int done_at = -1;
    int busy_seen = 0;
    logic busy_done_state = 1'b0;
    @(negedge clk);
    MulCtl = 4'b0100; SrcA = 32'd2; SrcB = 32'd9; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    for (int n = 1; n <= 75; n++) begin
      @(posedge clk); #1;
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == 33) busy_done_state = Busy;
      // n==5: pulse in ITER; n==33: pulse in the DONE-state cycle
      if (n == 5 || n == 33) begin
        Start = 1'b1; MulCtl = 4'b0100; SrcA = 32'd100; SrcB = 32'd100;
      end else begin
        Start = 1'b0;
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignored_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_at !== 34) begin errors++; $display("FAIL ignored_done_at: got %0d want 34", done_at); end
    checks++; if (busy_done_state !== 1'b1) begin errors++; $display("FAIL ignored_busy_in_done: got %b want 1", busy_done_state); end
    checks++; if (ResultLo !== 32'd18) begin errors++; $display("FAIL ignored_result: got %0d want 18", ResultLo); end
    // unsupported encoding in IDLE
    done_cnt = 0;
    @(negedge clk);
    MulCtl = 4'b0010; SrcA = 32'd3; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (Busy) busy_seen++;
      if (Done) done_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL unsupported_busy: got %0d busy cycles want 0", busy_seen); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL unsupported_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_flush();
    int done_cnt = 0;
    int busy_seen = 0;
    @(negedge clk);
    MulCtl = 4'b0100; SrcA = 32'd7; SrcB = 32'd9; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL flush_idle: got busy,done=%b want 00", {Busy, Done}); end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (Busy) busy_seen++;
      if (Done) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL flush_no_done: got %0d want 0", done_cnt); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL flush_stays_idle: got %0d busy cycles want 0", busy_seen); end
    checks++; if ({ResultHi, ResultLo} !== 64'd18) begin errors++; $display("FAIL flush_held: got %h_%h want 0_18", ResultHi, ResultLo); end
    // Flush and Start together in IDLE: Flush wins
    @(negedge clk);
    MulCtl = 4'b0100; SrcA = 32'd1; SrcB = 32'd1; Start = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start: got busy %b want 0", Busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    MulCtl = 4'b0100; SrcA = 32'h0000_FFFF; SrcB = 32'h0000_FFFF; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({Busy, Done, FlagsValid, FlagsNZ} !== 5'b0) begin errors++; $display("FAIL reset_mid_status: got %b want 00000", {Busy, Done, FlagsValid, FlagsNZ}); end
    checks++; if ({ResultHi, ResultLo} !== 64'd0) begin errors++; $display("FAIL reset_mid_result: got %h_%h want 0_0", ResultHi, ResultLo); end
    @(negedge clk);
    reset = 1'b1;
    run_op(4'b0100, 32'd3, 32'd5, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL post_reset_latency: got %0d want 34", lat); end
    checks++; if ({ResultHi, ResultLo} !== 64'd15) begin errors++; $display("FAIL post_reset_result: got %h_%h want 0_15", ResultHi, ResultLo); end
  endtask

  initial begin
    test_reset();
    test_umull_max();
    test_smulls();
    test_short_and_min();
    test_ignored_starts();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
